csi2_pkt_ctrl: RTL and testbench

//  Packet sequencer after the CSI-2 header ECC decoder. Splits the lane-merged
//  32-bit word stream into short and long packets, using the (ECC-corrected)

---
 rtl/csi2_pkt_ctrl_if.sv | 21 ++
 rtl/csi2_pkt_ctrl.sv | 157 +++++++++++++++
 tb/tb_csi2_pkt_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/csi2_pkt_ctrl_if.sv
// rtl/csi2_pkt_ctrl_if.sv - word stream from the ECC decoder and payload beats out of the packet sequencer
interface csi2_pkt_ctrl_if;
  logic        valid_i;
  logic [31:0] data_i;
  logic        hdr_err_i;
  logic        hdr_corr_i;
  logic        pld_valid_o;
  logic [31:0] pld_data_o;
  logic [3:0]  pld_keep_o;
  logic        pld_last_o;

  modport master (
    output valid_i, data_i, hdr_err_i, hdr_corr_i,
    input  pld_valid_o, pld_data_o, pld_keep_o, pld_last_o
  );

  modport slave (
    input  valid_i, data_i, hdr_err_i, hdr_corr_i,
    output pld_valid_o, pld_data_o, pld_keep_o, pld_last_o
  );
endinterface

// File: rtl/csi2_pkt_ctrl.sv
// rtl/csi2_pkt_ctrl.sv - CSI-2 packet sequencer: short-packet sync pulses, long-packet payload beats, CRC strip
module csi2_pkt_ctrl #(
  parameter logic [3:0] VC_MASK = 4'b1111,
  parameter int         CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  csi2_pkt_ctrl_if.slave   bus,
  output logic             pkt_done_o,
  output logic             frame_start_o,
  output logic             frame_end_o,
  output logic             line_start_o,
  output logic             line_end_o,
  output logic [15:0]      short_wc_o,
  output logic [1:0]       vc_o,
  output logic [5:0]       dt_o,
  output logic [15:0]      wc_o,
  output logic             hdr_drop_o,
  output logic             trunc_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  typedef enum logic [2:0] {IDLE, PLD, SKIP, DONE, WAIT} state_t;

  state_t      state_q, state_d;
  logic [14:0] cnt_q, cnt_d;
  logic [16:0] n_in, n_pl, cnt_ext;

  logic        pkt_done_d, fs_d, fe_d, ls_d, le_d, hdr_drop_d, trunc_d;
  logic [15:0] short_wc_d, wc_d;
  logic [1:0]  vc_d;
  logic [5:0]  dt_d;
  logic        pld_valid_d, pld_last_d;
  logic [31:0] pld_data_d;
  logic [3:0]  pld_keep_d;
  logic [CNT_W-1:0] drop_cnt_d;

  // Words in = payload + 2-byte CRC rounded up; payload beats = payload rounded up.
  assign n_in    = ({1'b0, wc_o} + 17'd5) >> 2;
  assign n_pl    = ({1'b0, wc_o} + 17'd3) >> 2;
  assign cnt_ext = {2'b00, cnt_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pkt_done_d  = (state_q == DONE);
    fs_d        = 1'b0;
    fe_d        = 1'b0;
    ls_d        = 1'b0;
    le_d        = 1'b0;
    hdr_drop_d  = 1'b0;
    trunc_d     = 1'b0;
    short_wc_d  = short_wc_o;
    wc_d        = wc_o;
    vc_d        = vc_o;
    dt_d        = dt_o;
    pld_valid_d = 1'b0;
    pld_last_d  = 1'b0;
    pld_data_d  = 32'h0;
    pld_keep_d  = 4'h0;
    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          if (bus.hdr_err_i && !bus.hdr_corr_i) begin
            hdr_drop_d = 1'b1;
            state_d    = SKIP;
          end else begin
            vc_d = bus.data_i[7:6];
            dt_d = bus.data_i[5:0];
            if (bus.data_i[5:4] == 2'b00) begin
              short_wc_d = bus.data_i[23:8];
              if (VC_MASK[bus.data_i[7:6]]) begin
                fs_d = (bus.data_i[5:0] == 6'h00);
                fe_d = (bus.data_i[5:0] == 6'h01);
                ls_d = (bus.data_i[5:0] == 6'h02);
                le_d = (bus.data_i[5:0] == 6'h03);
              end
              state_d = DONE;
            end else begin
              wc_d    = bus.data_i[23:8];
              cnt_d   = 15'd0;
              state_d = PLD;
            end
          end
        end
      end
      PLD: begin
        if (!bus.valid_i) begin
          trunc_d = 1'b1;
          state_d = DONE;
        end else begin
          if (cnt_ext < n_pl && VC_MASK[vc_o]) begin
            pld_valid_d = 1'b1;
            pld_data_d  = bus.data_i;
            pld_keep_d  = 4'hF;
            if (cnt_ext == n_pl - 17'd1) begin
              pld_last_d = 1'b1;
              pld_keep_d = (wc_o[1:0] == 2'b00) ? 4'hF : ((4'b0001 << wc_o[1:0]) - 4'd1);
            end
          end
          if (cnt_ext == n_in - 17'd1) state_d = DONE;
          else                         cnt_d   = cnt_q + 15'd1;
        end
      end
      SKIP: if (!bus.valid_i) state_d = DONE;
      DONE: state_d = WAIT;
      WAIT: if (!bus.valid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    drop_cnt_d = drop_cnt_o;
    if ((hdr_drop_d || trunc_d) && drop_cnt_o != {CNT_W{1'b1}})
      drop_cnt_d = drop_cnt_o + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q         <= IDLE;
      cnt_q           <= 15'd0;
      pkt_done_o      <= 1'b0;
      frame_start_o   <= 1'b0;
      frame_end_o     <= 1'b0;
      line_start_o    <= 1'b0;
      line_end_o      <= 1'b0;
      short_wc_o      <= 16'h0;
      vc_o            <= 2'd0;
      dt_o            <= 6'd0;
      wc_o            <= 16'h0;
      hdr_drop_o      <= 1'b0;
      trunc_o         <= 1'b0;
      drop_cnt_o      <= '0;
      bus.pld_valid_o <= 1'b0;
      bus.pld_data_o  <= 32'h0;
      bus.pld_keep_o  <= 4'h0;
      bus.pld_last_o  <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pkt_done_o      <= pkt_done_d;
      frame_start_o   <= fs_d;
      frame_end_o     <= fe_d;
      line_start_o    <= ls_d;
      line_end_o      <= le_d;
      short_wc_o      <= short_wc_d;
      vc_o            <= vc_d;
      dt_o            <= dt_d;
      wc_o            <= wc_d;
      hdr_drop_o      <= hdr_drop_d;
      trunc_o         <= trunc_d;
      drop_cnt_o      <= drop_cnt_d;
      bus.pld_valid_o <= pld_valid_d;
      bus.pld_data_o  <= pld_data_d;
      bus.pld_keep_o  <= pld_keep_d;
      bus.pld_last_o  <= pld_last_d;
    end
  end

endmodule

// File: tb/tb_csi2_pkt_ctrl.sv
// tb/tb_csi2_pkt_ctrl.sv - directed bench for csi2_pkt_ctrl with VC_MASK=4'b0001
module tb_csi2_pkt_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        pkt_done_o, frame_start_o, frame_end_o, line_start_o, line_end_o;
  logic [15:0] short_wc_o, wc_o, drop_cnt_o;
  logic [1:0]  vc_o;
  logic [5:0]  dt_o;
  logic        hdr_drop_o, trunc_o;
  int          checks = 0;
  int          failures = 0;

  csi2_pkt_ctrl_if bus ();

  csi2_pkt_ctrl #(.VC_MASK(4'b0001), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus),
    .pkt_done_o(pkt_done_o), .frame_start_o(frame_start_o), .frame_end_o(frame_end_o),
    .line_start_o(line_start_o), .line_end_o(line_end_o), .short_wc_o(short_wc_o),
    .vc_o(vc_o), .dt_o(dt_o), .wc_o(wc_o), .hdr_drop_o(hdr_drop_o), .trunc_o(trunc_o),
    .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] hdr(input logic [5:0] dt, input logic [1:0] vc, input logic [15:0] wc);
    return {8'h00, wc, vc, dt};
  endfunction

  // Drive one word at the falling edge, then leave outputs of the following rising edge visible.
  task automatic step(input logic v, input logic [31:0] d, input logic e = 1'b0, input logic c = 1'b0);
    @(negedge clk_i);
    bus.valid_i    = v;
    bus.data_i     = d;
    bus.hdr_err_i  = e;
    bus.hdr_corr_i = c;
    @(posedge clk_i);
    #1;
  endtask

  task automatic beat(input string tag, input logic v, input logic [31:0] d, input logic [3:0] k, input logic l);
    check_eq({tag, "_valid"}, {31'd0, bus.pld_valid_o}, {31'd0, v});
    if (v) begin
      check_eq({tag, "_data"}, bus.pld_data_o, d);
      check_eq({tag, "_keep"}, {28'd0, bus.pld_keep_o}, {28'd0, k});
    end
    check_eq({tag, "_last"}, {31'd0, bus.pld_last_o}, {31'd0, l});
  endtask

  initial begin
    bus.valid_i = 1'b0; bus.data_i = 32'h0; bus.hdr_err_i = 1'b0; bus.hdr_corr_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_pkt_done", {31'd0, pkt_done_o}, 32'd0);
    check_eq("rst_fields", {short_wc_o, wc_o}, 32'd0);
    check_eq("rst_vc_dt", {24'd0, vc_o, dt_o}, 32'd0);
    check_eq("rst_drop_cnt", {16'd0, drop_cnt_o}, 32'd0);
    check_eq("rst_pld_valid", {31'd0, bus.pld_valid_o}, 32'd0);
    @(negedge clk_i); rst_n_i = 1'b1;
    step(0, 0);

    // Short frame start
    step(1, hdr(6'h00, 2'd0, 16'h0007));
    check_eq("fs_pulse", {31'd0, frame_start_o}, 32'd1);
    check_eq("fs_short_wc", {16'd0, short_wc_o}, 32'd7);
    check_eq("fs_done_early", {31'd0, pkt_done_o}, 32'd0);
    step(0, 0);
    check_eq("fs_pulse_off", {31'd0, frame_start_o}, 32'd0);
    check_eq("fs_done", {31'd0, pkt_done_o}, 32'd1);
    step(0, 0);
    check_eq("fs_done_off", {31'd0, pkt_done_o}, 32'd0);

    // Long WC=10: three words in, extra fourth word discarded
    step(1, hdr(6'h2A, 2'd0, 16'd10));
    check_eq("l10_dt", {26'd0, dt_o}, 32'h2A);
    check_eq("l10_wc", {16'd0, wc_o}, 32'd10);
    beat("l10_hdr", 0, 0, 0, 0);
    step(1, 32'h03020100); beat("l10_b0", 1, 32'h03020100, 4'hF, 0);
    step(1, 32'h07060504); beat("l10_b1", 1, 32'h07060504, 4'hF, 0);
    step(1, 32'hC1C00908); beat("l10_b2", 1, 32'hC1C00908, 4'h3, 1);
    step(1, 32'hDEADBEEF); beat("l10_x", 0, 0, 0, 0);
    check_eq("l10_done", {31'd0, pkt_done_o}, 32'd1);
    step(0, 0); step(0, 0);

    // Long WC=7: CRC straddles words 1 and 2
    step(1, hdr(6'h2B, 2'd0, 16'd7));
    step(1, 32'h11111111); beat("l7_b0", 1, 32'h11111111, 4'hF, 0);
    step(1, 32'hC0222222); beat("l7_b1", 1, 32'hC0222222, 4'h7, 1);
    step(1, 32'h0000C1C2); beat("l7_crc", 0, 0, 0, 0);
    check_eq("l7_done_early", {31'd0, pkt_done_o}, 32'd0);
    step(0, 0);
    check_eq("l7_done", {31'd0, pkt_done_o}, 32'd1);
    step(0, 0);

    // Long WC=0: single CRC word, no beats
    step(1, hdr(6'h2B, 2'd0, 16'd0));
    step(1, 32'h0000C1C2); beat("l0_crc", 0, 0, 0, 0);
    step(0, 0);
    check_eq("l0_done", {31'd0, pkt_done_o}, 32'd1);
    step(0, 0);

    // Uncorrectable header: burst of 5 words skipped
    step(1, hdr(6'h12, 2'd0, 16'd8), 1'b1, 1'b0);
    check_eq("drop_pulse", {31'd0, hdr_drop_o}, 32'd1);
    check_eq("drop_cnt1", {16'd0, drop_cnt_o}, 32'd1);
    check_eq("drop_dt_held", {26'd0, dt_o}, 32'h2B);
    for (int i = 0; i < 4; i++) begin
      step(1, 32'hAAAA0000 + i);
      beat("drop_w", 0, 0, 0, 0);
      check_eq("drop_no_done", {31'd0, pkt_done_o}, 32'd0);
    end
    step(0, 0);
    check_eq("drop_done_early", {31'd0, pkt_done_o}, 32'd0);
    step(0, 0);
    check_eq("drop_done", {31'd0, pkt_done_o}, 32'd1);
    step(0, 0);

    // Corrected header is accepted
    step(1, hdr(6'h01, 2'd0, 16'h0042), 1'b1, 1'b1);
    check_eq("corr_fe", {31'd0, frame_end_o}, 32'd1);
    check_eq("corr_swc", {16'd0, short_wc_o}, 32'h42);
    step(0, 0); step(0, 0);

    // Truncated long packet
    step(1, hdr(6'h2C, 2'd0, 16'd16));
    step(1, 32'h44332211); beat("tr_b0", 1, 32'h44332211, 4'hF, 0);
    step(1, 32'h88776655); beat("tr_b1", 1, 32'h88776655, 4'hF, 0);
    step(0, 0);
    check_eq("tr_pulse", {31'd0, trunc_o}, 32'd1);
    beat("tr_end", 0, 0, 0, 0);
    check_eq("tr_drop_cnt", {16'd0, drop_cnt_o}, 32'd2);
    step(0, 0);
    check_eq("tr_done", {31'd0, pkt_done_o}, 32'd1);
    check_eq("tr_pulse_off", {31'd0, trunc_o}, 32'd0);
    step(0, 0);
    step(1, hdr(6'h02, 2'd0, 16'd5));
    check_eq("tr_next_ls", {31'd0, line_start_o}, 32'd1);
    check_eq("tr_next_swc", {16'd0, short_wc_o}, 32'd5);
    step(0, 0); step(0, 0);

    // Masked VC: short pulse suppressed, fields still latch
    step(1, hdr(6'h03, 2'd2, 16'd9));
    check_eq("mask_le", {31'd0, line_end_o}, 32'd0);
    check_eq("mask_vc", {30'd0, vc_o}, 32'd2);
    step(0, 0);
    check_eq("mask_s_done", {31'd0, pkt_done_o}, 32'd1);
    step(0, 0);

    // Masked VC long packet: consumed without beats
    step(1, hdr(6'h2A, 2'd1, 16'd4));
    step(1, 32'h12345678); beat("mask_w0", 0, 0, 0, 0);
    step(1, 32'h0000C1C2); beat("mask_w1", 0, 0, 0, 0);
    step(0, 0);
    check_eq("mask_l_done", {31'd0, pkt_done_o}, 32'd1);
    step(0, 0);

    // Async reset mid-payload
    step(1, hdr(6'h2A, 2'd0, 16'd8));
    step(1, 32'hCAFEF00D); beat("rst_mid_b0", 1, 32'hCAFEF00D, 4'hF, 0);
    @(negedge clk_i); rst_n_i = 1'b0;
    #1;
    beat("rst_mid", 0, 0, 0, 0);
    check_eq("rst_mid_wc", {16'd0, wc_o}, 32'd0);
    check_eq("rst_mid_cnt", {16'd0, drop_cnt_o}, 32'd0);
    bus.valid_i = 1'b0;
    @(negedge clk_i); rst_n_i = 1'b1;
    step(0, 0);
    step(1, hdr(6'h00, 2'd0, 16'd3));
    check_eq("rst_recover_fs", {31'd0, frame_start_o}, 32'd1);
    step(0, 0);
    check_eq("rst_recover_done", {31'd0, pkt_done_o}, 32'd1);
    step(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
